conv3x3_engine: RTL and testbench

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

---
 rtl/conv3x3_engine.sv | 175 +++++++++++++++++
 tb/tb_conv3x3_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: three-stage 3x3 convolution (multiply, accumulate, shift/saturate) with frame position tracking.
// Define CONV3X3_RELU_EN for unsigned ReLU-clamped output; otherwise the output is saturated two's complement.
module conv3x3_engine #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int SHIFT        = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [7:0]          win1,
  input  logic [7:0]          win2,
  input  logic [7:0]          win3,
  input  logic [7:0]          win4,
  input  logic [7:0]          win5,
  input  logic [7:0]          win6,
  input  logic [7:0]          win7,
  input  logic [7:0]          win8,
  input  logic [7:0]          win9,
  input  logic [7:0]          stage_width,
  input  logic [7:0]          stage_height,
  input  logic                w_load,
  input  logic [3:0]          w_addr,
  input  logic signed [7:0]   w_data,
  input  logic signed [15:0]  bias,
  output logic [7:0]          out_pixel,
  output logic                out_valid,
  output logic                frame_done
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = 17;
  localparam int ACC_W  = 21;
  localparam int BIAS_W = 16;

  localparam logic [7:0] MAX_W = (IMAGE_WIDTH  > 255) ? 8'd255 : 8'(IMAGE_WIDTH);
  localparam logic [7:0] MAX_H = (IMAGE_HEIGHT > 255) ? 8'd255 : 8'(IMAGE_HEIGHT);

  function automatic logic [7:0] clamp_dim(input logic [7:0] v, input logic [7:0] max_v);
    if (v < 8'd3)  return 8'd3;
    if (v > max_v) return max_v;
    return v;
  endfunction

  function automatic logic signed [PROD_W-1:0] mul(input logic [DATA_W-1:0] px,
                                                   input logic signed [COEF_W-1:0] c);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = {{(PROD_W-DATA_W){1'b0}}, px};
    b = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
    return a * b;
  endfunction

`ifdef CONV3X3_RELU_EN
  function automatic logic [7:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1])   return 8'd0;
    if (v > 21'sd255) return 8'd255;
    return v[7:0];
  endfunction
`else
  function automatic logic [7:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v < -21'sd128) return 8'h80;
    if (v > 21'sd127)  return 8'h7f;
    return v[7:0];
  endfunction
`endif

  logic [7:0]                eff_w;
  logic [7:0]                eff_h;
  logic [7:0]                col;
  logic [7:0]                row;
  logic [DATA_W-1:0]         win [9];
  logic signed [COEF_W-1:0]  coef [9];
  logic                      win_ok;
  logic                      at_end;

  logic signed [PROD_W-1:0]  prod_p0 [9];
  logic                      vld_p0;
  logic                      last_p0;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   acc_p1;
  logic                      vld_p1;
  logic                      last_p1;
  logic signed [ACC_W-1:0]   acc_sh;

  assign win[0] = win1;
  assign win[1] = win2;
  assign win[2] = win3;
  assign win[3] = win4;
  assign win[4] = win5;
  assign win[5] = win6;
  assign win[6] = win7;
  assign win[7] = win8;
  assign win[8] = win9;

  assign eff_w  = clamp_dim(stage_width,  MAX_W);
  assign eff_h  = clamp_dim(stage_height, MAX_H);
  assign win_ok = in_valid && (col >= 8'd2) && (row >= 8'd2);
  assign at_end = (col == eff_w - 8'd1) && (row == eff_h - 8'd1);

  // Wrap on >= so a mid-frame shrink of the active size still recovers at the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col >= eff_w - 8'd1) begin
        col <= '0;
        row <= (row >= eff_h - 8'd1) ? 8'd0 : row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  // A write lands at the same edge that samples the window, so that window sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) coef[i] <= '0;
    end else if (w_load) begin
      for (int i = 0; i < 9; i++)
        if (w_addr == 4'(i)) coef[i] <= w_data;
    end
  end

  // Stage boundary p0: nine products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      for (int i = 0; i < 9; i++) prod_p0[i] <= '0;
    end else begin
      vld_p0  <= win_ok;
      last_p0 <= win_ok && at_end;
      if (win_ok)
        for (int i = 0; i < 9; i++) prod_p0[i] <= mul(win[i], coef[i]);
    end
  end

  always_comb begin
    acc_sum = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
    for (int i = 0; i < 9; i++)
      acc_sum = acc_sum + {{(ACC_W-PROD_W){prod_p0[i][PROD_W-1]}}, prod_p0[i]};
  end

  // Stage boundary p1: accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      acc_p1  <= '0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      if (vld_p0) acc_p1 <= acc_sum;
    end
  end

  assign acc_sh = acc_p1 >>> SHIFT;

  // Stage boundary p2: shifted, saturated output; bubbles leave out_pixel untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_pixel  <= '0;
    end else begin
      out_valid  <= vld_p1;
      frame_done <= vld_p1 && last_p1;
      if (vld_p1) out_pixel <= saturate(acc_sh);
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// tb_conv3x3_engine: randomized frames checked cycle by cycle against a pixel-position reference model.
// Honours CONV3X3_RELU_EN the same way the design does.
module tb_conv3x3_engine;

  localparam int IW   = 128;
  localparam int IH   = 128;
  localparam int SH   = 7;
  localparam int MAXC = 32768;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [7:0]         win [9];
  logic [7:0]         stage_width = 8'd4;
  logic [7:0]         stage_height = 8'd4;
  logic               w_load = 1'b0;
  logic [3:0]         w_addr = 4'd0;
  logic signed [7:0]  w_data = 8'sd0;
  logic signed [15:0] bias = 16'sd0;
  logic [7:0]         out_pixel;
  logic               out_valid;
  logic               frame_done;

  logic signed [7:0]  mcoef [9];
  int                 pos = 0;
  int                 force_px = -1;
  bit                 exp_v [MAXC];
  bit                 exp_d [MAXC];
  int                 exp_p [MAXC];
  int                 held = 0;
  int                 cyc = 0;
  int                 obs_v = 0;
  int                 obs_d = 0;
  int                 errors = 0;
  int                 checks = 0;

  conv3x3_engine #(.IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .win1(win[0]), .win2(win[1]), .win3(win[2]), .win4(win[3]), .win5(win[4]),
    .win6(win[5]), .win7(win[6]), .win8(win[7]), .win9(win[8]),
    .stage_width(stage_width), .stage_height(stage_height),
    .w_load(w_load), .w_addr(w_addr), .w_data(w_data), .bias(bias),
    .out_pixel(out_pixel), .out_valid(out_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int eff(input int v, input int mx);
    if (v < 3)  return 3;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic int sat_ref(input int v);
    int s;
`ifdef CONV3X3_RELU_EN
    s = (v < 0) ? 0 : ((v > 255) ? 255 : v);
`else
    s = (v < -128) ? -128 : ((v > 127) ? 127 : v);
`endif
    return s & 255;
  endfunction

  // Reference: pixel number within the frame gives (row, col); result due three cycles later.
  task automatic model_accept();
    int w, h, c, r, acc;
    w = eff(int'(stage_width), IW);
    h = eff(int'(stage_height), IH);
    c = pos % w;
    r = pos / w;
    if (c >= 2 && r >= 2) begin
      acc = int'(bias);
      for (int k = 0; k < 9; k++) acc += int'(win[k]) * int'(mcoef[k]);
      exp_v[cyc+3] = 1'b1;
      exp_p[cyc+3] = sat_ref(acc >>> SH);
      exp_d[cyc+3] = (c == w - 1) && (r == h - 1);
    end
    pos = (pos + 1) % (w * h);
  endtask

  task automatic step(input bit v, input bit wl, input logic [3:0] wa, input logic signed [7:0] wd);
    @(posedge clk);
    #1;
    if (cyc + 8 >= MAXC) begin
      $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC - 8);
      $fatal(1, "cycle budget exhausted");
    end
    in_valid = v;
    w_load   = wl;
    w_addr   = wa;
    w_data   = wd;
    for (int k = 0; k < 9; k++) win[k] = (force_px >= 0) ? 8'(force_px) : 8'($urandom);
    if (v) model_accept();
    if (wl && wa < 4'd9) mcoef[wa] = wd;
  endtask

  task automatic load_coef(input int a, input int d);
    step(1'b0, 1'b1, 4'(a), 8'(d));
  endtask

  task automatic random_coefs();
    for (int i = 0; i < 9; i++) load_coef(i, int'($urandom_range(0, 255)));
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    w_load   = 1'b0;
    for (int i = cyc; i < cyc + 8; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = 1'b0;
    end
    pos = 0;
    for (int i = 0; i < 9; i++) mcoef[i] = 8'sd0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // mode 0: continuous, 1: alternate valid/idle, 2: random valid with random coefficient writes
  task automatic run_frame(input int w, input int h, input int mode, input int load_at);
    int fw, fh, nacc, t;
    bit v;
    stage_width  = 8'(w);
    stage_height = 8'(h);
    fw = eff(w, IW);
    fh = eff(h, IH);
    obs_v = 0;
    obs_d = 0;
    nacc = 0;
    t = 0;
    while (nacc < fw * fh) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (v && nacc == load_at)
        step(1'b1, 1'b1, 4'd4, 8'sd2);
      else if (mode == 2 && $urandom_range(0, 15) == 0)
        step(v, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
      else
        step(v, 1'b0, 4'd0, 8'sd0);
      if (v) nacc++;
      t++;
    end
    repeat (5) step(1'b0, 1'b0, 4'd0, 8'sd0);
    check("count_valid", obs_v, (fw - 2) * (fh - 2));
    check("count_done", obs_d, 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_out_pixel", int'(out_pixel), 0);
    end else begin
      if (exp_v[cyc]) held = exp_p[cyc];
      check("out_valid", int'(out_valid), int'(exp_v[cyc]));
      check("frame_done", int'(frame_done), int'(exp_d[cyc]));
      check(exp_v[cyc] ? "out_pixel" : "out_pixel_hold", int'(out_pixel), held);
      if (out_valid) obs_v++;
      if (frame_done) obs_d++;
    end
  end

  initial begin
    for (int k = 0; k < 9; k++) begin
      win[k] = 8'd0;
      mcoef[k] = 8'sd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    random_coefs();
    run_frame(4, 4, 0, -1);
    run_frame(5, 5, 1, -1);

    random_coefs();
    load_coef(4, -5);
    run_frame(5, 5, 0, 12);

    for (int i = 0; i < 9; i++) load_coef(i, (i == 4) ? 127 : 0);
    bias = 16'sd127;
    force_px = 255;
    run_frame(3, 3, 0, -1);
`ifdef CONV3X3_RELU_EN
    check("centre_tap", int'(out_pixel), 254);
`else
    check("centre_tap", int'(out_pixel), 127);
`endif

    for (int i = 0; i < 9; i++) load_coef(i, -128);
    bias = 16'sd0;
    run_frame(3, 3, 0, -1);
`ifdef CONV3X3_RELU_EN
    check("neg_saturate", int'(out_pixel), 0);
`else
    check("neg_saturate", int'(out_pixel), 128);
`endif
    force_px = -1;

    for (int f = 0; f < 12; f++) begin
      random_coefs();
      bias = 16'($urandom);
      run_frame(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 2, -1);
    end

    random_coefs();
    bias = 16'sd0;
    run_frame(200, 3, 0, -1);

    random_coefs();
    stage_width  = 8'd5;
    stage_height = 8'd5;
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 4'd0, 8'sd0);
    step(1'b0, 1'b0, 4'd0, 8'sd0);
    do_reset(2);
    repeat (6) step(1'b0, 1'b0, 4'd0, 8'sd0);
    bias = -16'sd300;
    run_frame(4, 4, 0, -1);
`ifdef CONV3X3_RELU_EN
    check("post_reset_zero_coef", int'(out_pixel), 0);
`else
    check("post_reset_zero_coef", int'(out_pixel), 253);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
